mips_multicycle_ctrl: RTL and testbench

- Multi-cycle control sequencer for the single-cycle MIPS datapath (register file, sign extend, ALU, data memory, muxes).
- Accepts one instruction at a time over a valid/ready handshake, latches it and drives it to the datapath.
- Decodes it and sequences RegDst, ALUSrc, ALUCtrl, MemRead, MemWrite, MemtoReg and RegWrite through DECODE/EXEC/MEM/WB phases.
- The register file writes on the RegWrite rising edge, so every write strobe is a clean single-cycle pulse issued only after all static controls have been stable for at least one cycle.

---
 rtl/mips_ctrl_pkg.sv | 51 +++++
 rtl/mips_decoder.sv | 70 +++++++
 rtl/mips_multicycle_ctrl.sv | 144 ++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: opcode/funct constants, ALU control encodings, FSM state enum,
//           and the static control bundle produced by the decoder.
package mips_ctrl_pkg;

  // Primary opcodes [31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct field [5:0]
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation select, must match the datapath ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // Per-instruction control bundle. mem_read/mem_write/reg_write here are
  // "this instruction needs it" flags; the FSM turns them into timed strobes.
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [3:0] alu_ctrl;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/mips_decoder.sv
// Maps opcode/funct to the static control bundle plus an illegal flag.
// Latency: purely combinational.
// Backpressure: none.
// Ports: opcode, funct, rt, rd in; ctrl (bundle), illegal out.
module mips_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output ctrl_t      ctrl,
  output logic       illegal
);

  logic [4:0] dest;

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    dest    = 5'd0;

    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_ctrl = ALU_ADD;
          FN_SUB:  ctrl.alu_ctrl = ALU_SUB;
          FN_AND:  ctrl.alu_ctrl = ALU_AND;
          FN_OR:   ctrl.alu_ctrl = ALU_OR;
          FN_NOR:  ctrl.alu_ctrl = ALU_NOR;
          FN_SLT:  ctrl.alu_ctrl = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_ctrl   = ALU_ADD;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.mem_write = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    // Illegal instructions must not leak any control into the datapath.
    if (illegal) begin
      ctrl = '0;
    end

    // Writes to $0 are dropped; the instruction still retires normally.
    dest = ctrl.reg_dst ? rt : rd;
    if (dest == 5'd0) begin
      ctrl.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control sequencer: accepts one instruction, drives datapath controls.
// Latency: R/addi done at +4, lw at +4+MEM_WAIT, sw at +3+MEM_WAIT from acceptance.
// Backpressure: instrReady only in IDLE; instrValid is ignored elsewhere.
// Ports: clk, rst_n; instrIn/instrValid/instrReady handshake; instruction to
//        datapath; RegDst, ALUSrc, ALUCtrl, MemRead, MemWrite, MemtoReg,
//        RegWrite controls; done/illegalInstr pulses; retiredCount.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT    = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            instrIn,
  input  logic                   instrValid,
  output logic                   instrReady,
  output logic [31:0]            instruction,
  output logic                   RegDst,
  output logic                   ALUSrc,
  output logic [3:0]             ALUCtrl,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   MemtoReg,
  output logic                   RegWrite,
  output logic                   done,
  output logic                   illegalInstr,
  output logic [COUNT_WIDTH-1:0] retiredCount
);

  localparam logic [3:0] MEM_LAST = 4'(MEM_WAIT - 1);

  state_e                 state_q, state_d;
  logic [31:0]            instr_q;
  ctrl_t                  ctrl_q, ctrl_d;
  ctrl_t                  dec_ctrl;
  logic                   dec_illegal;
  logic [3:0]             mem_cnt_q, mem_cnt_d;
  logic                   accept;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic                   reg_write_q, reg_write_d;
  logic                   done_q, done_d;
  logic                   illegal_q, illegal_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;

  // Decode straight off instrIn so the bundle is registered on acceptance
  // and already stable during the DECODE cycle.
  mips_decoder u_decoder (
    .opcode  (instrIn[31:26]),
    .funct   (instrIn[5:0]),
    .rt      (instrIn[20:16]),
    .rd      (instrIn[15:11]),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign accept = (state_q == S_IDLE) && instrValid;

  always_comb begin
    state_d     = state_q;
    mem_cnt_d   = 4'd0;
    ctrl_d      = ctrl_q;
    illegal_d   = 1'b0;
    retired_d   = retired_q;

    case (state_q)
      S_IDLE:   if (instrValid) state_d = S_DECODE;
      S_DECODE: state_d = illegal_q ? S_IDLE : S_EXEC;
      S_EXEC:   state_d = (ctrl_q.mem_read || ctrl_q.mem_write) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_cnt_q == MEM_LAST) begin
          state_d = ctrl_q.mem_read ? S_WB : S_DONE;
        end else begin
          mem_cnt_d = mem_cnt_q + 4'd1;
        end
      end
      S_WB:     state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (accept) begin
      ctrl_d    = dec_ctrl;
      illegal_d = dec_illegal;
    end else if (state_d == S_IDLE) begin
      ctrl_d = '0;
    end

    // Strobes are computed for the upcoming state and registered, so each
    // one leaves a flop as a clean pulse while static controls are already
    // stable from DECODE onward.
    mem_read_d  = ctrl_q.mem_read && ((state_d == S_MEM) || (state_d == S_WB));
    mem_write_d = ctrl_q.mem_write && (state_d == S_MEM) && (state_q != S_MEM);
    reg_write_d = ctrl_q.reg_write && (state_d == S_WB);
    done_d      = (state_d == S_DONE);

    if (done_d) begin
      retired_d = retired_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      instr_q     <= 32'd0;
      ctrl_q      <= '0;
      mem_cnt_q   <= 4'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      if (accept) begin
        instr_q <= instrIn;
      end
      ctrl_q      <= ctrl_d;
      mem_cnt_q   <= mem_cnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
      retired_q   <= retired_d;
    end
  end

  assign instrReady   = (state_q == S_IDLE);
  assign instruction  = instr_q;
  assign RegDst       = ctrl_q.reg_dst;
  assign ALUSrc       = ctrl_q.alu_src;
  assign ALUCtrl      = ctrl_q.alu_ctrl;
  assign MemtoReg     = ctrl_q.mem_to_reg;
  assign MemRead      = mem_read_q;
  assign MemWrite     = mem_write_q;
  assign RegWrite     = reg_write_q;
  assign done         = done_q;
  assign illegalInstr = illegal_q;
  assign retiredCount = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: two instances share stimulus,
// a (MEM_WAIT=2, 16-bit count) and b (MEM_WAIT=1, 4-bit count for wrap).
// Per-cycle strobe activity is collected as bit masks indexed by cycle.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instrIn = 32'd0;
  logic        instrValid = 1'b0;

  logic        rdy_a, rdst_a, asrc_a, mr_a, mw_a, m2r_a, rw_a, dn_a, il_a;
  logic [3:0]  actl_a;
  logic [31:0] instr_a;
  logic [15:0] ret_a;
  logic        rdy_b, rdst_b, asrc_b, mr_b, mw_b, m2r_b, rw_b, dn_b, il_b;
  logic [3:0]  actl_b;
  logic [31:0] instr_b;
  logic [3:0]  ret_b;

  int checks = 0;
  int failures = 0;

  // Per-cycle masks (bit c = cycle c after acceptance) and cycle-1 statics
  logic [15:0] k_rw_a, k_mr_a, k_mw_a, k_dn_a, k_il_a, k_rdy_a;
  logic [15:0] k_rw_b, k_mw_b, k_dn_b;
  logic        s_rdst_a, s_asrc_a, s_m2r_a;
  logic [3:0]  s_actl_a;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_WAIT(2), .COUNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .instrIn(instrIn), .instrValid(instrValid),
    .instrReady(rdy_a), .instruction(instr_a), .RegDst(rdst_a), .ALUSrc(asrc_a),
    .ALUCtrl(actl_a), .MemRead(mr_a), .MemWrite(mw_a), .MemtoReg(m2r_a),
    .RegWrite(rw_a), .done(dn_a), .illegalInstr(il_a), .retiredCount(ret_a)
  );

  mips_multicycle_ctrl #(.MEM_WAIT(1), .COUNT_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .instrIn(instrIn), .instrValid(instrValid),
    .instrReady(rdy_b), .instruction(instr_b), .RegDst(rdst_b), .ALUSrc(asrc_b),
    .ALUCtrl(actl_b), .MemRead(mr_b), .MemWrite(mw_b), .MemtoReg(m2r_b),
    .RegWrite(rw_b), .done(dn_b), .illegalInstr(il_b), .retiredCount(ret_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer ins at a falling edge (cycle 0), then record n cycles.
  task automatic run(input logic [31:0] ins, input int n);
    k_rw_a = '0; k_mr_a = '0; k_mw_a = '0; k_dn_a = '0; k_il_a = '0; k_rdy_a = '0;
    k_rw_b = '0; k_mw_b = '0; k_dn_b = '0;
    instrIn = ins;
    instrValid = 1'b1;
    @(posedge clk);
    #1 instrValid = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      k_rw_a[c] = rw_a; k_mr_a[c] = mr_a; k_mw_a[c] = mw_a;
      k_dn_a[c] = dn_a; k_il_a[c] = il_a; k_rdy_a[c] = rdy_a;
      k_rw_b[c] = rw_b; k_mw_b[c] = mw_b; k_dn_b[c] = dn_b;
      if (c == 1) begin
        s_rdst_a = rdst_a; s_asrc_a = asrc_a; s_m2r_a = m2r_a; s_actl_a = actl_a;
      end
    end
  endtask

  logic [31:0] alu_ins [5] = '{32'h00221822, 32'h00221824, 32'h00221825,
                               32'h00221827, 32'h0022182A};
  logic [3:0]  alu_exp [5] = '{4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
  logic        seen_done;

  initial begin
    // Reset state
    #3;
    check("rst_ready", rdy_a, 1);
    check("rst_regwrite", rw_a, 0);
    check("rst_done", dn_a, 0);
    check("rst_retired", ret_a, 0);
    check("rst_instruction", instr_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // add $3,$1,$2
    run(32'h00221820, 6);
    check("add_regdst", s_rdst_a, 0);
    check("add_alusrc", s_asrc_a, 0);
    check("add_aluctrl", s_actl_a, 4'b0010);
    check("add_rw_mask", k_rw_a, 16'h0008);
    check("add_done_mask", k_dn_a, 16'h0010);
    check("add_mr_mask", k_mr_a, 16'h0000);
    check("add_instruction", instr_a, 32'h00221820);
    check("add_retired", ret_a, 1);

    // lw $5,8($1) on MEM_WAIT=2
    run(32'h8C250008, 8);
    check("lw_regdst", s_rdst_a, 1);
    check("lw_alusrc", s_asrc_a, 1);
    check("lw_memtoreg", s_m2r_a, 1);
    check("lw_mr_mask", k_mr_a, 16'h0038);
    check("lw_rw_mask", k_rw_a, 16'h0020);
    check("lw_done_mask", k_dn_a, 16'h0040);
    check("lw_mw_mask", k_mw_a, 16'h0000);
    check("lw_retired", ret_a, 2);

    // sw $5,4($1): b has MEM_WAIT=1, a has MEM_WAIT=2
    run(32'hAC250004, 8);
    check("sw_b_mw_mask", k_mw_b, 16'h0008);
    check("sw_b_rw_mask", k_rw_b, 16'h0000);
    check("sw_b_done_mask", k_dn_b, 16'h0010);
    check("sw_a_mw_mask", k_mw_a, 16'h0008);
    check("sw_a_done_mask", k_dn_a, 16'h0020);
    check("sw_a_regdst", s_rdst_a, 0);
    check("sw_retired", ret_a, 3);

    // Illegal opcode
    run(32'hFC000000, 4);
    check("ill_op_pulse", k_il_a, 16'h0002);
    check("ill_op_strobes", k_rw_a | k_mw_a | k_mr_a | k_dn_a, 0);
    check("ill_op_ready", k_rdy_a[2:1], 2'b10);
    check("ill_op_retired", ret_a, 3);

    // Illegal funct under R-type (addu)
    run(32'h00221821, 4);
    check("ill_fn_pulse", k_il_a, 16'h0002);
    check("ill_fn_strobes", k_rw_a | k_dn_a, 0);

    // addi $0,$1,5: write suppressed but retires
    run(32'h20200005, 6);
    check("addi0_rw_mask", k_rw_a, 16'h0000);
    check("addi0_done_mask", k_dn_a, 16'h0010);
    check("addi0_retired", ret_a, 4);

    // addi $2,$1,5
    run(32'h20220005, 6);
    check("addi_rw_mask", k_rw_a, 16'h0008);
    check("addi_regdst", s_rdst_a, 1);
    check("addi_alusrc", s_asrc_a, 1);
    check("addi_aluctrl", s_actl_a, 4'b0010);

    // Remaining R-type ALU encodings
    for (int i = 0; i < 5; i++) begin
      run(alu_ins[i], 6);
      check($sformatf("rtype_aluctrl_%0d", i), s_actl_a, alu_exp[i]);
      check($sformatf("rtype_rw_%0d", i), k_rw_a, 16'h0008);
    end
    check("rtype_retired", ret_a, 10);

    // instrValid held while busy must be ignored
    instrIn = 32'h00221820;
    instrValid = 1'b1;
    @(posedge clk);
    #1 instrIn = 32'hFC000000;
    repeat (2) @(negedge clk);
    instrValid = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_instruction", instr_a, 32'h00221820);
    check("busy_retired", ret_a, 11);

    // Reset during WB of a lw
    instrIn = 32'h8C250008;
    instrValid = 1'b1;
    @(posedge clk);
    #1 instrValid = 1'b0;
    repeat (5) @(negedge clk);
    check("wb_rw_before", rw_a, 1);
    check("wb_mr_before", mr_a, 1);
    rst_n = 1'b0;
    #1;
    check("wb_rw_after_rst", rw_a, 0);
    check("wb_mr_after_rst", mr_a, 0);
    check("wb_ready_after_rst", rdy_a, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      seen_done = seen_done | dn_a;
    end
    check("wb_rst_no_done", seen_done, 0);
    check("wb_rst_retired", ret_a, 0);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 15; i++) run(32'h00221820, 5);
    check("wrap_b_15", ret_b, 15);
    run(32'h00221820, 5);
    check("wrap_b_0", ret_b, 0);
    check("wrap_a_16", ret_a, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
